// File: rtl/seq_pkg.sv
// Shared types and sizing for the program sequencer: FSM states, store geometry
// and the NOP instruction placed on the bus outside of issue cycles.
package seq_pkg;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LW    = 5;
  localparam logic [LW-1:0] FULL_LEN = 5'd16;
  localparam logic [15:0]   NOP_INST = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: 16x16 words, synchronous write, asynchronous read.
// Contents are deliberately not reset; the sequencer's length register gates access.
module seq_prog_mem
  import seq_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem_q [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_sequencer.sv
// Loads a short program, then replays it to an external processor one instruction
// every two cycles (issue, then capture), with repeat passes, halt-on-zero and abort.
module prog_sequencer
  import seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic        clear,
  input  logic        start,
  input  logic [3:0]  rep_count,
  input  logic        halt_on_zero,
  input  logic        abort,
  output logic [15:0] inst,
  input  logic [7:0]  result_in,
  input  logic        zero_in,
  output logic        res_valid,
  output logic [7:0]  res_data,
  output logic        busy,
  output logic        done,
  output logic        halted_zero
);

  state_e          state_q, state_d;
  logic [LW-1:0]   prog_len_q, prog_len_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [3:0]      pass_q, pass_d;
  logic [3:0]      rep_q, rep_d;
  logic            hoz_q, hoz_d;
  logic            zero_q, zero_d;
  logic            halted_q, halted_d;
  logic [7:0]      res_data_q, res_data_d;
  logic [15:0]     inst_q, inst_d;
  logic            res_valid_q, res_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            mem_we_s;
  logic            load_ready_s;
  logic [15:0]     mem_rdata_s;

  seq_prog_mem u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (prog_len_q[AW-1:0]),
    .wdata (load_data),
    .raddr (pc_d),
    .rdata (mem_rdata_s)
  );

  // next-state, datapath and registered-output decode
  always_comb begin
    state_d      = state_q;
    prog_len_d   = prog_len_q;
    pc_d         = pc_q;
    pass_d       = pass_q;
    rep_d        = rep_q;
    hoz_d        = hoz_q;
    zero_d       = zero_q;
    halted_d     = halted_q;
    res_data_d   = res_data_q;
    mem_we_s     = 1'b0;
    load_ready_s = (state_q == ST_IDLE) && (prog_len_q < FULL_LEN) && !start && !clear;

    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          prog_len_d = 5'd0;
        end else if (start && (prog_len_q != 5'd0)) begin
          pc_d     = 4'd0;
          pass_d   = 4'd0;
          rep_d    = rep_count;
          hoz_d    = halt_on_zero;
          halted_d = 1'b0;
          state_d  = ST_ISSUE;
        end else if (load_valid && load_ready_s) begin
          mem_we_s   = 1'b1;
          prog_len_d = prog_len_q + 5'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          res_data_d = result_in;
          zero_d     = zero_in;
          state_d    = ST_CAPT;
        end
      end
      ST_CAPT: begin
        // abort outranks every normal capture transition
        if (abort) begin
          state_d = ST_IDLE;
        end else if (zero_q && hoz_q) begin
          halted_d = 1'b1;
          state_d  = ST_DONE;
        end else if (({1'b0, pc_q} + 5'd1) < prog_len_q) begin
          pc_d    = pc_q + 4'd1;
          state_d = ST_ISSUE;
        end else if (pass_q < rep_q) begin
          pass_d  = pass_q + 4'd1;
          pc_d    = 4'd0;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // outputs are decoded from the next state so they appear registered
    inst_d      = (state_d == ST_ISSUE) ? mem_rdata_s : NOP_INST;
    busy_d      = (state_d == ST_ISSUE) || (state_d == ST_CAPT);
    res_valid_d = (state_d == ST_CAPT);
    done_d      = (state_d == ST_DONE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prog_len_q  <= 5'd0;
      pc_q        <= 4'd0;
      pass_q      <= 4'd0;
      rep_q       <= 4'd0;
      hoz_q       <= 1'b0;
      zero_q      <= 1'b0;
      halted_q    <= 1'b0;
      res_data_q  <= 8'h00;
      inst_q      <= NOP_INST;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prog_len_q  <= prog_len_d;
      pc_q        <= pc_d;
      pass_q      <= pass_d;
      rep_q       <= rep_d;
      hoz_q       <= hoz_d;
      zero_q      <= zero_d;
      halted_q    <= halted_d;
      res_data_q  <= res_data_d;
      inst_q      <= inst_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign load_ready  = load_ready_s;
  assign inst        = inst_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign halted_zero = halted_q;

endmodule
